// File: rtl/ycr1_pipe_div.sv
// ycr1_pipe_div: iterative restoring 32/32 divider (DIV/DIVU/REM/REMU) with a sign-fix cycle.
// Define YCR1_DIV_FAST_EN to resolve divide-by-zero and |Din1| < |Din2| in a single compute cycle.
module ycr1_pipe_div #(
  parameter int unsigned ITER_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [32:0] Din1,
  input  logic [32:0] Din2,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_rdy_o,
  input  logic        data_done
);

  localparam int unsigned NumCycles = 32 / ITER_PER_CYCLE;
  localparam logic [4:0]  CntLast   = 5'(NumCycles - 1);

  typedef enum logic [1:0] {
    StWaitCmd,
    StWaitComp,
    StWaitDone,
    StWaitExit
  } state_e;

  state_e      state_q, state_d;

  logic [31:0] dvd_q;      // dividend, shifted left; collects quotient bits at the LSB
  logic [31:0] dvs_q;
  logic [31:0] rem_q;
  logic [4:0]  cnt_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        dz_q;
  logic [31:0] quotient_q;
  logic [31:0] remainder_q;
  logic        rdy_q, rdy_d;

  logic        ld_cmd;
  logic        do_step;
  logic        do_fix;
  logic        comp_last;

  logic [31:0] mag1, mag2;
  logic        dz_in;

  logic [31:0] dvd_step;
  logic [31:0] rem_step;
  logic [32:0] rem_sh;
  logic [31:0] rem_diff;

`ifdef YCR1_DIV_FAST_EN
  logic        fast_q;
`endif

  // Magnitude of a sign/value operand; 0x80000000 maps onto itself as an unsigned value.
  function automatic logic [31:0] mag(input logic [32:0] v);
    return v[32] ? (32'd0 - v[31:0]) : v[31:0];
  endfunction

  assign mag1  = mag(Din1);
  assign mag2  = mag(Din2);
  assign dz_in = (Din2[31:0] == 32'd0);

`ifdef YCR1_DIV_FAST_EN
  assign comp_last = (cnt_q == CntLast) || fast_q;
`else
  assign comp_last = (cnt_q == CntLast);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StWaitCmd;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitCmd:  if (data_valid) state_d = StWaitComp;
      StWaitComp: if (comp_last) state_d = StWaitDone;
      StWaitDone: state_d = StWaitExit;
      // Exit only once the consumer has actually seen div_rdy_o.
      StWaitExit: if (data_done && rdy_q) state_d = StWaitCmd;
      default:    state_d = StWaitCmd;
    endcase
  end

  // Control outputs
  always_comb begin
    ld_cmd  = (state_q == StWaitCmd) && data_valid;
    do_step = (state_q == StWaitComp);
    do_fix  = (state_q == StWaitDone);
    rdy_d   = (state_q == StWaitExit) && !(data_done && rdy_q);
  end

  // ITER_PER_CYCLE restoring steps per clock
  always_comb begin
    dvd_step = dvd_q;
    rem_step = rem_q;
    rem_sh   = '0;
    rem_diff = '0;
    for (int unsigned i = 0; i < ITER_PER_CYCLE; i++) begin
      rem_sh   = {rem_step, dvd_step[31]};
      rem_diff = rem_sh[31:0] - dvs_q;
      dvd_step = {dvd_step[30:0], 1'b0};
      if (rem_sh >= {1'b0, dvs_q}) begin
        rem_step    = rem_diff;
        dvd_step[0] = 1'b1;
      end else begin
        rem_step = rem_sh[31:0];
      end
    end
`ifdef YCR1_DIV_FAST_EN
    if (fast_q) begin
      dvd_step = {32{dz_q}};
      rem_step = dvd_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      rdy_q       <= 1'b0;
`ifdef YCR1_DIV_FAST_EN
      fast_q      <= 1'b0;
`endif
    end else begin
      rdy_q <= rdy_d;
      if (ld_cmd) begin
        q_neg_q <= Din1[32] ^ Din2[32];
        r_neg_q <= Din1[32];
        dz_q    <= dz_in;
        dvd_q   <= mag1;
        dvs_q   <= mag2;
        rem_q   <= '0;
        cnt_q   <= '0;
`ifdef YCR1_DIV_FAST_EN
        fast_q  <= dz_in || (mag1 < mag2);
`endif
      end else if (do_step) begin
        dvd_q <= dvd_step;
        rem_q <= rem_step;
        cnt_q <= cnt_q + 5'd1;
      end
      // Divide by zero keeps the all-ones quotient unsigned.
      if (do_fix) begin
        quotient_q  <= dz_q ? 32'hFFFF_FFFF : (q_neg_q ? (32'd0 - dvd_q) : dvd_q);
        remainder_q <= r_neg_q ? (32'd0 - rem_q) : rem_q;
      end
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_rdy_o = rdy_q;

endmodule

// File: tb/tb_ycr1_pipe_div.sv
// Self-checking bench for ycr1_pipe_div: directed vectors, handshake, reset and random operands.
module tb_ycr1_pipe_div;

  localparam int unsigned ITER  = 1;
  localparam int unsigned NCYC  = 32 / ITER;
  localparam int          LIMIT = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic [32:0] Din1;
  logic [32:0] Din2;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_rdy_o;
  logic        data_done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ycr1_pipe_div #(
    .ITER_PER_CYCLE(ITER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_valid(data_valid),
    .Din1      (Din1),
    .Din2      (Din2),
    .quotient  (quotient),
    .remainder (remainder),
    .div_rdy_o (div_rdy_o),
    .data_done (data_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] magn(input logic [32:0] v);
    logic [31:0] m;
    m = v[31:0];
    if (v[32]) m = 32'd0 - m;
    return m;
  endfunction

  // Reference: plain unsigned division on magnitudes, then the sign rules.
  function automatic void model(input logic [32:0] a, input logic [32:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    logic [31:0] ma, mb;
    ma = magn(a);
    mb = magn(b);
    if (mb == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a[31:0];
    end else begin
      q = ma / mb;
      r = ma % mb;
      if (a[32] ^ b[32]) q = 32'd0 - q;
      if (a[32]) r = 32'd0 - r;
    end
  endfunction

  function automatic int exp_lat(input logic [32:0] a, input logic [32:0] b);
`ifdef YCR1_DIV_FAST_EN
    if (magn(b) == 32'd0 || magn(a) < magn(b)) return 3;
`endif
    return NCYC + 2;
  endfunction

  function automatic logic [32:0] rnd_opnd();
    logic [32:0] v;
    v = {1'($urandom_range(1)), $urandom()};
    v[31:0] = v[31:0] >> $urandom_range(31);
    return v;
  endfunction

  // Called #1 after the accepting edge; waits for div_rdy_o and checks everything.
  task automatic wait_result(input string tag, input logic [32:0] a, input logic [32:0] b,
                             input logic [31:0] eq, input logic [31:0] er, input int glitch_at);
    int lat;
    lat = 0;
    data_valid = 1'b0;
    Din1 = rnd_opnd();
    Din2 = rnd_opnd();
    while (div_rdy_o !== 1'b1 && lat < LIMIT) begin
      if (glitch_at != 0 && lat == glitch_at) begin
        data_valid = 1'b1;
        Din1 = 33'h0_0000_1234;
        Din2 = 33'h0_0000_0003;
      end else begin
        data_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    data_valid = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat(a, b)));
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
  endtask

  task automatic start_op(input logic [32:0] a, input logic [32:0] b);
    @(negedge clk);
    Din1 = a;
    Din2 = b;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    data_done = 1'b1;
    @(posedge clk);
    #1;
    data_done = 1'b0;
    check({tag, " rdy drop"}, 32'(div_rdy_o), 32'd0);
  endtask

  typedef struct {
    logic [32:0] a;
    logic [32:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] eq, er, hq, hr;
    logic [32:0] a, b;
    int bad;

    vecs[0] = '{33'h0_0000_0064, 33'h0_0000_0007, 32'h0000_000E, 32'h0000_0002};
    vecs[1] = '{33'h1_FFFF_FF9C, 33'h0_0000_0007, 32'hFFFF_FFF2, 32'hFFFF_FFFE};
    vecs[2] = '{33'h1_FFFF_FF9C, 33'h1_FFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE};
    vecs[3] = '{33'h1_FFFF_FFFB, 33'h0_0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    vecs[4] = '{33'h0_FFFF_FFFF, 33'h0_0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5] = '{33'h1_8000_0000, 33'h1_FFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    vecs[6] = '{33'h0_FFFF_FFFF, 33'h0_0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{33'h0_0000_0003, 33'h0_0000_0007, 32'h0000_0000, 32'h0000_0003};

    rst = 1'b1;
    data_valid = 1'b0;
    data_done = 1'b0;
    Din1 = '0;
    Din2 = '0;
    #1;
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset rdy", 32'(div_rdy_o), 32'd0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with constant expectations
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_result($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 0);
      release_result($sformatf("vec%0d", i));
    end

    // data_valid pulsed mid-computation is ignored
    start_op(33'h0_0000_0064, 33'h0_0000_0007);
    wait_result("ignore valid", 33'h0_0000_0064, 33'h0_0000_0007, 32'h0000_000E, 32'h0000_0002, 5);

    // Result and ready hold while data_done stays low
    hq = quotient;
    hr = remainder;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (div_rdy_o !== 1'b1 || quotient !== hq || remainder !== hr) bad++;
    end
    check("hold stable", 32'(bad), 32'd0);

    // data_done and data_valid together: exit only, accept on the following edge
    a = 33'h1_FFFF_FF9C;
    b = 33'h0_0000_0007;
    @(negedge clk);
    data_done = 1'b1;
    data_valid = 1'b1;
    Din1 = a;
    Din2 = b;
    @(posedge clk);
    #1;
    data_done = 1'b0;
    check("done+valid rdy drop", 32'(div_rdy_o), 32'd0);
    @(posedge clk);
    #1;
    wait_result("done+valid", a, b, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0);
    release_result("done+valid");

    // Async reset during computation, then a clean operation
    start_op(33'h0_0000_0064, 33'h0_0000_0007);
    data_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset quotient", quotient, 32'd0);
    check("midreset remainder", remainder, 32'd0);
    check("midreset rdy", 32'(div_rdy_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start_op(33'h0_0000_0064, 33'h0_0000_0007);
    wait_result("after reset", 33'h0_0000_0064, 33'h0_0000_0007, 32'h0000_000E,
                32'h0000_0002, 0);
    release_result("after reset");

    // Random operands against the reference model
    for (int i = 0; i < 24; i++) begin
      a = rnd_opnd();
      b = rnd_opnd();
      if (i % 8 == 7) b[31:0] = 32'd0;
      model(a, b, eq, er);
      start_op(a, b);
      wait_result($sformatf("rnd%0d a=%09h b=%09h", i, a, b), a, b, eq, er, 0);
      release_result($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ycr1_pipe_div.md
Name: ycr1_pipe_div

Overview:
- Iterative 32/32 integer divider for the pipeline EXU: the inverse operation to the 8-stage multiplier, sharing its command/ready/done handshake.
- Operands are 33-bit; bit[32] is the sign, so DIV/DIVU/REM/REMU all map onto one block.
- Works on magnitudes with restoring radix-2 iterations, then applies a sign-fix cycle.
- Returns quotient and remainder together and holds them until the consumer signals completion.

Parameters:
- ITER_PER_CYCLE, 1, restoring iterations per clock; legal values 1, 2, 4. Gives N = 32/ITER_PER_CYCLE compute cycles.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-high reset
- data_valid  input  1  command valid; sampled only in WAIT_CMD
- Din1  input  33  dividend; bit[32]=1 means negative two's-complement in [31:0]
- Din2  input  33  divisor; same encoding
- quotient  output  32  signed/unsigned quotient
- remainder  output  32  remainder; sign follows dividend
- div_rdy_o  output  1  result valid; registered
- data_done  input  1  consumer finished with result

Behaviour:
- Reset: state=WAIT_CMD; quotient, remainder, div_rdy_o, all internal registers = 0. Reset mid-operation aborts with no residual state.
- States:
  - WAIT_CMD: on data_valid, latch q_neg = Din1[32]^Din2[32], r_neg = Din1[32], dz = (Din2[31:0]==0). Load |Din1| into the working dividend and |Din2| into the divisor (negate when bit[32]=1; 0x80000000 stays 0x80000000 as unsigned). Clear the partial remainder and cycle counter. Go to WAIT_COMP.
  - WAIT_COMP: each clock performs ITER_PER_CYCLE restoring steps:
    - rem' = {rem[31:0], dividend MSB}; shift the dividend left.
    - If rem' >= divisor (33-bit compare): rem = rem'-divisor and shift in q bit 1; else rem = rem' and q bit 0.
    - Counter 0..N-1; when count==N-1, go to WAIT_DONE.
  - WAIT_DONE: one cycle, sign fix.
    - quotient = dz ? 0xFFFFFFFF : (q_neg ? -q : q).
    - remainder = r_neg ? -rem : rem.
    - Go to WAIT_EXIT.
  - WAIT_EXIT: div_rdy_o=1, registered and high for the whole state. On data_done go to WAIT_CMD; div_rdy_o is low from the next edge.
- Latency: div_rdy_o rises N+2 clocks after the accepting edge (34 at ITER_PER_CYCLE=1, 18 at 2, 10 at 4).
- Din1/Din2 are not referenced after the accepting edge and may change freely.
- data_valid outside WAIT_CMD is ignored, with no queuing. data_done outside WAIT_EXIT is ignored.
- data_valid and data_done both high in WAIT_EXIT: only the exit is taken. The new command is accepted no earlier than the following clock in WAIT_CMD.
- Divide by zero needs no special datapath: all q bits resolve to 1 and rem=|dividend|. dz only suppresses quotient negation; the remainder returns the original dividend.
- Signed overflow (0x80000000 neg / 0x00000001 neg) gives quotient 0x80000000, remainder 0. This follows from the magnitude path with q_neg=0.
- quotient/remainder hold their value from WAIT_DONE until the next WAIT_DONE.

Optional Feature:
- Macro: YCR1_DIV_FAST_EN.
- Defined:
  - On the accepting edge, compute fast = dz or (|Din1| < |Din2|).
  - When fast is set, WAIT_COMP lasts exactly one clock and forces q=dz ? 0xFFFFFFFF : 0 and rem=|dividend|, then proceeds to WAIT_DONE as normal.
  - div_rdy_o rises 3 clocks after accept. Results are bit-identical to the slow path.
- Undefined: no compare logic is present and every command takes N+2 cycles.

Test Plan:
- Din1=0x0_00000064 (100), Din2=0x0_00000007 -> quotient=0x0000000E, remainder=0x00000002, div_rdy_o high exactly 34 clks after accept (ITER_PER_CYCLE=1).
- Din1=0x1_FFFFFF9C (-100), Din2=0x0_00000007 -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE; Din2=0x1_FFFFFFF9 (-7) -> quotient=0x0000000E, remainder=0xFFFFFFFE.
- Din1=0x1_FFFFFFFB (-5), Din2=0x0_00000000 -> quotient=0xFFFFFFFF, remainder=0xFFFFFFFB; unsigned Din1=0x0_FFFFFFFF /0 -> quotient=0xFFFFFFFF, remainder=0xFFFFFFFF.
- Din1=0x1_80000000, Din2=0x1_FFFFFFFF -> quotient=0x80000000, remainder=0; unsigned 0x0_FFFFFFFF/0x0_00000001 -> 0xFFFFFFFF, 0.
- Handshake:
  - Pulse data_valid with new operands during WAIT_COMP -> ignored, result unchanged.
  - Hold data_done low 20 clks -> div_rdy_o and results stay stable.
  - data_done=1 -> div_rdy_o low next clk and the next command is accepted.
- Assert rst at compute cycle 10 -> all outputs 0 immediately (async). After release, 100/7 completes correctly. With YCR1_DIV_FAST_EN, 3/7 -> quotient=0, remainder=3, div_rdy_o 3 clks after accept.
